fp_alu_op_sequencer: RTL and testbench
======================================

Name: fp_alu_op_sequencer

Overview:
Upstream issue stage for the combinational floating-point ALU (adder/multiplier selected by `selector`).
- Accepts operation requests over a valid/ready handshake and registers the operands and selector.
- Holds those operands stable on the ALU inputs for a programmable settle time, then captures Result/carry/overflow.
- Presents the captured result over an output valid/ready handshake.
- Masks the ALU's stale flag outputs, keeps a sticky overflow flag, and counts completed operations.

Parameters:
- SETTLE_CYCLES, 2, cycles the ALU inputs are held before capture; legal range 1..15, 0 is illegal.
- COUNT_WIDTH, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at a clk edge.
- in_a  in  32  IEEE-754 single operand A.
- in_b  in  32  IEEE-754 single operand B.
- in_sel  in  1  0 = add, 1 = multiply.
- alu_a  out  32  registered operand A to the ALU.
- alu_b  out  32  registered operand B to the ALU.
- alu_sel  out  1  registered selector to the ALU.
- alu_result  in  32  ALU Result.
- alu_carry  in  1  ALU carry.
- alu_overflow  in  1  ALU overflow.
- out_valid  out  1  captured result valid.
- out_ready  in  1  consumer ready.
- out_result  out  32  captured result.
- out_carry  out  1  captured carry; 0 when the op was a multiply.
- out_overflow  out  1  captured overflow; 0 when the op was an add.
- clear_sticky  in  1  clears sticky_overflow.
- sticky_overflow  out  1  set by any captured overflow.
- op_count  out  COUNT_WIDTH  completed output handshakes, saturating.

Behaviour:
- Reset (rst high at an edge):
  - state = IDLE.
  - alu_a, alu_b, alu_sel, out_result, out_carry, out_overflow, out_valid, sticky_overflow and op_count all go to 0.
  - in_ready is 0 while rst is high.
  - Reset mid-operation discards the in-flight op; no output is produced for it.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - in_ready = 1.
  - On accept: register in_a, in_b and in_sel onto alu_a, alu_b and alu_sel; load settle counter = SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - in_ready = 0; alu_* outputs are held constant.
  - Counter decrements each cycle.
  - In the cycle where the counter is 0, capture at that edge:
    - out_result = alu_result.
    - out_carry = alu_carry & ~alu_sel.
    - out_overflow = alu_overflow & alu_sel.
    - out_valid goes to 1; next state is HOLD.
- HOLD:
  - out_valid = 1; out_* outputs are held stable until handshake.
  - in_ready = out_ready (combinational, from state and out_ready).
  - On out_valid & out_ready:
    - op_count increments, saturating at all-ones.
    - If in_valid is also high at the same edge, the new request is accepted; go directly to SETTLE with out_valid deasserted next cycle.
    - Otherwise go to IDLE.
- Latency: request accepted at edge T → alu_* driven from cycle T+1 → out_valid high from cycle T+SETTLE_CYCLES+1. Example: SETTLE_CYCLES=2 gives out_valid at T+3.
- Throughput: one op per SETTLE_CYCLES+1 cycles with out_ready held high.
- Sticky overflow:
  - Set at the capture edge if out_overflow is being captured as 1.
  - clear_sticky clears it at an edge.
  - Simultaneous set and clear: set wins.
- Flag masking exists because the ALU leaves carry undriven-stale during multiply and overflow stale during add. Downstream must never see those stale values.
- in_valid dropping without handshake has no effect; there is no requirement on stability of in_* while in_ready=0.
- op_count at all-ones stays all-ones on further handshakes.

Test Plan:
- Add 0x3F800000 + 0x40000000, sel=0, SETTLE_CYCLES=2, out_ready=1 → out_valid at T+3 for 1 cycle; out_result=0x40400000, out_carry=0, out_overflow=0; op_count=1.
- Multiply 0x40000000 * 0x40400000, sel=1 → out_result=0x40C00000, out_overflow=0, out_carry=0 regardless of the alu_carry value.
- Multiply 0x7F000000 * 0x7F000000 → out_result=0x7F800000, out_overflow=1, sticky_overflow=1. Then pulse clear_sticky → 0. Pulse clear_sticky on the same edge as a new overflow capture → sticky remains 1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD with a second request pending → out_* stable, in_ready=0. Raise out_ready → same-edge handshake and accept; second result appears SETTLE_CYCLES+1 cycles later.
- Reset asserted during SETTLE → next cycle out_valid=0, alu_*=0, op_count=0, state IDLE; no result emitted for the dropped op.
- Force op_count to 0xFFFE via 0xFFFE ops (or COUNT_WIDTH=4 with 15 ops) → two more handshakes leave op_count at all-ones.

Source files
------------

// File: rtl/fp_alu_op_sequencer.sv
// fp_alu_op_sequencer
//   Issue stage in front of a combinational floating-point ALU (add/mul).
//   A request is registered onto the ALU inputs and held for SETTLE_CYCLES
//   cycles. The ALU result and flags are then captured and presented on a
//   valid/ready output.
//   Flags the ALU leaves stale are masked: carry on multiply, overflow on add.
//   A sticky overflow flag and a saturating count of completed ops are kept.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        request handshake; in_a, in_b, in_sel operands
//   alu_a/alu_b/alu_sel      registered operands driven to the ALU
//   alu_result/carry/ovf     ALU outputs, sampled at the capture edge
//   out_valid/out_ready      result handshake; out_result/carry/overflow
//   clear_sticky             clears sticky_overflow (a new overflow wins)
//   sticky_overflow          set by any captured overflow
//   op_count                 completed output handshakes, saturating
//
// SETTLE_CYCLES must be in 1..15.
module fp_alu_op_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned COUNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_a,
   input  logic [31:0]            in_b,
   input  logic                   in_sel,
   output logic [31:0]            alu_a,
   output logic [31:0]            alu_b,
   output logic                   alu_sel,
   input  logic [31:0]            alu_result,
   input  logic                   alu_carry,
   input  logic                   alu_overflow,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_result,
   output logic                   out_carry,
   output logic                   out_overflow,
   input  logic                   clear_sticky,
   output logic                   sticky_overflow,
   output logic [COUNT_WIDTH-1:0] op_count
);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t                 state_q;
   logic [3:0]             cnt_q;
   logic [31:0]            alu_a_q, alu_b_q, res_q;
   logic                   alu_sel_q, carry_q, ovf_q, vld_q;
   logic                   sticky_q, sticky_d;
   logic [COUNT_WIDTH-1:0] cnt_ops_q, cnt_ops_d;
   logic                   accept, capture, out_fire, ovf_masked;

   // In HOLD a new request may be taken only on the same edge that
   // drains the current result.
   assign in_ready   = ~rst & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
   assign accept     = in_valid & in_ready;
   assign capture    = (state_q == SETTLE) && (cnt_q == 4'd0);
   assign out_fire   = (state_q == HOLD) & out_ready;
   assign ovf_masked = alu_overflow & alu_sel_q;

   always_comb begin
      sticky_d  = (capture & ovf_masked) | (sticky_q & ~clear_sticky);
      cnt_ops_d = cnt_ops_q;
      if (out_fire && (cnt_ops_q != {COUNT_WIDTH{1'b1}}))
         cnt_ops_d = cnt_ops_q + COUNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sel_q <= 1'b0;
         res_q     <= '0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         vld_q     <= 1'b0;
         sticky_q  <= 1'b0;
         cnt_ops_q <= '0;
      end else begin
         sticky_q  <= sticky_d;
         cnt_ops_q <= cnt_ops_d;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  alu_a_q   <= in_a;
                  alu_b_q   <= in_b;
                  alu_sel_q <= in_sel;
                  cnt_q     <= CNT_LOAD;
                  state_q   <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt_q == 4'd0) begin
                  res_q   <= alu_result;
                  carry_q <= alu_carry & ~alu_sel_q;
                  ovf_q   <= ovf_masked;
                  vld_q   <= 1'b1;
                  state_q <= HOLD;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  vld_q <= 1'b0;
                  if (accept) begin
                     alu_a_q   <= in_a;
                     alu_b_q   <= in_b;
                     alu_sel_q <= in_sel;
                     cnt_q     <= CNT_LOAD;
                     state_q   <= SETTLE;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign alu_a           = alu_a_q;
   assign alu_b           = alu_b_q;
   assign alu_sel         = alu_sel_q;
   assign out_valid       = vld_q;
   assign out_result      = res_q;
   assign out_carry       = carry_q;
   assign out_overflow    = ovf_q;
   assign sticky_overflow = sticky_q;
   assign op_count        = cnt_ops_q;

endmodule

// File: tb/tb_fp_alu_op_sequencer.sv
// Directed bench for fp_alu_op_sequencer (SETTLE_CYCLES=2, COUNT_WIDTH=4).
// The bench plays the role of the ALU by driving alu_result/carry/overflow.
module tb_fp_alu_op_sequencer;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, in_sel, alu_sel;
   logic [31:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
   logic        alu_carry, alu_overflow, out_valid, out_ready, out_carry, out_overflow;
   logic        clear_sticky, sticky_overflow;
   logic [3:0]  op_count;
   int          tests = 0;
   int          fails = 0;

   fp_alu_op_sequencer #(.SETTLE_CYCLES(2), .COUNT_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_carry(out_carry), .out_overflow(out_overflow),
      .clear_sticky(clear_sticky), .sticky_overflow(sticky_overflow),
      .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic setup(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] r, input logic c, input logic o);
      in_a = a; in_b = b; in_sel = s;
      alu_result = r; alu_carry = c; alu_overflow = o;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear_sticky = 1'b0;
      setup(32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick(); tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
      tests++; if ({alu_a, alu_b, alu_sel} !== 65'h0) begin fails++; $display("FAIL reset_alu got %h %h %b exp 0", alu_a, alu_b, alu_sel); end
      tests++; if ({out_result, out_carry, out_overflow, sticky_overflow, op_count} !== 39'h0) begin fails++; $display("FAIL reset_outs got %h %b %b %b %h exp 0", out_result, out_carry, out_overflow, sticky_overflow, op_count); end
      rst = 1'b0; #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready got %b exp 1", in_ready); end
   endtask

   // Add with a stale overflow on the ALU: it must be masked.
   task automatic test_add();
      setup(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b1);
      in_valid = 1'b1;
      tick(); in_valid = 1'b0;                                     // accept edge T
      tests++; if ({alu_a, alu_b, alu_sel} !== {32'h3F800000, 32'h40000000, 1'b0}) begin fails++; $display("FAIL add_alu_regs got %h %h %b", alu_a, alu_b, alu_sel); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL add_settle_in_ready got %b exp 0", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_valid_T1 got %b exp 0", out_valid); end
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_valid_T2 got %b exp 0", out_valid); end
      tick();
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_valid_T3 got %b exp 1", out_valid); end
      tests++; if ({out_result, out_carry, out_overflow} !== {32'h40400000, 2'b00}) begin fails++; $display("FAIL add_result got %h %b %b exp 40400000 0 0", out_result, out_carry, out_overflow); end
      tests++; if (sticky_overflow !== 1'b0) begin fails++; $display("FAIL add_sticky got %b exp 0", sticky_overflow); end
      tick();                                                      // handshake
      tests++; if (out_valid !== 1'b0 || op_count !== 4'd1) begin fails++; $display("FAIL add_done got valid %b count %0d exp 0 1", out_valid, op_count); end
   endtask

   // Multiply with a stale carry on the ALU: it must be masked.
   task automatic test_mul();
      setup(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 1'b1, 1'b0);
      in_valid = 1'b1; tick(); in_valid = 1'b0; tick(); tick();
      tests++; if ({out_valid, out_result, out_carry, out_overflow} !== {1'b1, 32'h40C00000, 2'b00}) begin fails++; $display("FAIL mul_result got %b %h %b %b exp 1 40c00000 0 0", out_valid, out_result, out_carry, out_overflow); end
      tick();
      tests++; if (op_count !== 4'd2) begin fails++; $display("FAIL mul_count got %0d exp 2", op_count); end
   endtask

   task automatic test_overflow();
      setup(32'h7F000000, 32'h7F000000, 1'b1, 32'h7F800000, 1'b0, 1'b1);
      in_valid = 1'b1; tick(); in_valid = 1'b0; tick(); tick();
      tests++; if ({out_result, out_overflow, sticky_overflow} !== {32'h7F800000, 2'b11}) begin fails++; $display("FAIL ovf_result got %h %b %b exp 7f800000 1 1", out_result, out_overflow, sticky_overflow); end
      tick();
      clear_sticky = 1'b1; tick(); clear_sticky = 1'b0;
      tests++; if (sticky_overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b exp 0", sticky_overflow); end
      // Clear held through the whole op, including the capture edge: set wins.
      clear_sticky = 1'b1;
      in_valid = 1'b1; tick(); in_valid = 1'b0; tick(); tick();
      tests++; if (sticky_overflow !== 1'b1) begin fails++; $display("FAIL ovf_set_wins got %b exp 1", sticky_overflow); end
      clear_sticky = 1'b0; tick();
      tests++; if (op_count !== 4'd4) begin fails++; $display("FAIL ovf_count got %0d exp 4", op_count); end
      clear_sticky = 1'b1; tick(); clear_sticky = 1'b0;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      setup(32'h11111111, 32'h22222222, 1'b0, 32'hAAAA0001, 1'b1, 1'b0);
      in_valid = 1'b1; tick(); tick(); tick();                     // in HOLD
      setup(32'h33333333, 32'h44444444, 1'b1, 32'hAAAA0001, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tests++; if ({out_valid, out_result, out_carry, in_ready, alu_a} !== {1'b1, 32'hAAAA0001, 1'b1, 1'b0, 32'h11111111}) begin fails++; $display("FAIL bp_hold%0d got %b %h %b %b %h", i, out_valid, out_result, out_carry, in_ready, alu_a); end
         tick();
      end
      out_ready = 1'b1; alu_result = 32'hBBBB0002; alu_overflow = 1'b0; #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_in_ready got %b exp 1", in_ready); end
      tick(); in_valid = 1'b0;                                     // handshake + accept
      tests++; if ({out_valid, alu_a, alu_sel, op_count} !== {1'b0, 32'h33333333, 1'b1, 4'd5}) begin fails++; $display("FAIL bp_accept got %b %h %b %0d", out_valid, alu_a, alu_sel, op_count); end
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_second_early got %b exp 0", out_valid); end
      tick();
      tests++; if ({out_valid, out_result, out_carry} !== {1'b1, 32'hBBBB0002, 1'b0}) begin fails++; $display("FAIL bp_second got %b %h %b", out_valid, out_result, out_carry); end
      tick();
      tests++; if (op_count !== 4'd6) begin fails++; $display("FAIL bp_count got %0d exp 6", op_count); end
   endtask

   task automatic test_reset_mid_op();
      setup(32'h55555555, 32'h66666666, 1'b1, 32'h77777777, 1'b0, 1'b1);
      in_valid = 1'b1; tick(); in_valid = 1'b0; tick();           // in SETTLE
      rst = 1'b1; tick();
      tests++; if ({out_valid, alu_a, alu_b, alu_sel, op_count, sticky_overflow, in_ready} !== 72'h0) begin fails++; $display("FAIL rst_mid got %b %h %h %b %0d %b %b", out_valid, alu_a, alu_b, alu_sel, op_count, sticky_overflow, in_ready); end
      rst = 1'b0; #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_idle got %b exp 1", in_ready); end
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_noout%0d got %b exp 0", i, out_valid); end
      end
   endtask

   // One op with out_ready high; bounded wait for the result.
   task automatic run_op(input logic [31:0] r);
      int n;
      setup(r, r, 1'b0, r, 1'b0, 1'b0);
      in_valid = 1'b1; tick(); in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 10) begin tick(); n++; end
      tests++; if (out_valid !== 1'b1 || out_result !== r) begin fails++; $display("FAIL sat_op got valid %b result %h exp 1 %h", out_valid, out_result, r); end
      tick();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 15; i++) run_op(32'h1000 + 32'(i));
      tests++; if (op_count !== 4'hF) begin fails++; $display("FAIL sat_15 got %0d exp 15", op_count); end
      run_op(32'hCAFE0000); run_op(32'hCAFE0001);
      tests++; if (op_count !== 4'hF) begin fails++; $display("FAIL sat_hold got %0d exp 15", op_count); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_overflow();
      test_back_to_back();
      test_reset_mid_op();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
